// File: rtl/tulip_pkg.sv
// Shared tulip codebase constants and helpers used as parameter defaults
// and for counter sizing across the audio blocks.
package tulip_pkg;

    localparam int C_ADC_DWIDTH    = 24;
    localparam int C_I2S_SLOT_BITS = 32;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: toggles i2s_bclk every G_BCLK_DIV clk cycles and
// strobes fall in the cycle the bit clock goes from 1 to 0.
module i2s_bclk_gen
    import tulip_pkg::*;
#(
    parameter int G_BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic i2s_bclk,
    output logic fall
);

    localparam int            CW         = cnt_width(G_BCLK_DIV);
    localparam logic [CW-1:0] C_DIV_LAST = CW'(G_BCLK_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        div_cnt_d = div_cnt_q + CW'(1);
        bclk_d    = bclk_q;
        wrap      = (div_cnt_q == C_DIV_LAST);
        if (wrap) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs, independent of statement order.
        if (!reset_n || !enable) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign i2s_bclk = bclk_q;
    assign fall     = reset_n & enable & wrap & bclk_q;

endmodule

// File: rtl/i2s_dac_transmitter.sv
// Mono I2S DAC transmitter: buffers one sample from the DSP chain and sends it
// MSB first in both the left and right slots of each frame.
module i2s_dac_transmitter
    import tulip_pkg::*;
#(
    parameter int G_DWIDTH    = C_ADC_DWIDTH,
    parameter int G_BCLK_DIV  = 4,
    parameter int G_SLOT_BITS = C_I2S_SLOT_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [G_DWIDTH-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                underrun_clear,
    output logic                underrun,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int            BW     = cnt_width(2 * G_SLOT_BITS);
    localparam int            IW     = cnt_width(G_DWIDTH);
    localparam logic [BW-1:0] C_SLOT = BW'(G_SLOT_BITS);
    localparam logic [BW-1:0] C_LAST = BW'(2 * G_SLOT_BITS - 1);

    logic                run;
    logic                fall;
    logic                capture;
    logic                frame_start;
    logic                underrun_set;
    logic [BW-1:0]       next_bit;
    logic [BW-1:0]       slot_pos;
    logic [31:0]         pos32;
    logic [IW-1:0]       bit_idx;

    logic [G_DWIDTH-1:0] hold_reg_q, hold_reg_d;
    logic                hold_valid_q, hold_valid_d;
    logic [G_DWIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic                underrun_q, underrun_d;

    i2s_bclk_gen #(
        .G_BCLK_DIV (G_BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .i2s_bclk (i2s_bclk),
        .fall     (fall)
    );

    assign run       = reset_n & enable;
    assign din_ready = run & ~hold_valid_q;
    assign capture   = din_valid & din_ready;

    always_comb begin
        hold_reg_d   = hold_reg_q;
        hold_valid_d = hold_valid_q;
        shift_reg_d  = shift_reg_q;
        bit_cnt_d    = bit_cnt_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;

        next_bit     = (bit_cnt_q == C_LAST) ? '0 : bit_cnt_q + BW'(1);
        slot_pos     = (next_bit >= C_SLOT) ? next_bit - C_SLOT : next_bit;
        pos32        = 32'(slot_pos);
        bit_idx      = IW'(32'(G_DWIDTH) - pos32);
        frame_start  = fall && (next_bit == '0);
        underrun_set = frame_start && !hold_valid_q;

        if (fall) begin
            bit_cnt_d = next_bit;
            lrclk_d   = (next_bit >= C_SLOT);
            sdata_d   = 1'b0;
            if ((pos32 >= 32'd1) && (pos32 <= 32'(G_DWIDTH))) begin
                sdata_d = shift_reg_q[bit_idx];
            end
            // The frame-start load frees the buffer; din_ready was low this
            // cycle if it was full, so no capture can collide with the load.
            if (frame_start) begin
                shift_reg_d  = hold_valid_q ? hold_reg_q : '0;
                hold_valid_d = 1'b0;
            end
        end

        if (capture) begin
            hold_reg_d   = din;
            hold_valid_d = 1'b1;
        end

        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clear) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            hold_valid_q <= 1'b0;
            shift_reg_q  <= '0;
            bit_cnt_q    <= C_LAST;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            underrun_q   <= underrun_d;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; hold_valid_q
    // qualifies it, so its contents are never used before a capture.
    always_ff @(posedge clk) begin
        hold_reg_q <= hold_reg_d;
    end

    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Bench for i2s_dac_transmitter: a frame-level timing model checked every cycle,
// plus directed scenarios with hand-computed slot words.
module tb_i2s_dac_transmitter;

    localparam int DW   = 24;
    localparam int DIV  = 2;
    localparam int SLOT = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          underrun_clear;
    logic          underrun;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;

    int vectors     = 0;
    int miscompares = 0;

    i2s_dac_transmitter #(
        .G_DWIDTH    (DW),
        .G_BCLK_DIV  (DIV),
        .G_SLOT_BITS (SLOT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .underrun_clear (underrun_clear),
        .underrun       (underrun),
        .i2s_bclk       (i2s_bclk),
        .i2s_lrclk      (i2s_lrclk),
        .i2s_sdata      (i2s_sdata)
    );

    always #5 clk = ~clk;

    // Model state: time since release drives all serial timing arithmetically.
    int            n_edges   = 0;
    int            cyc       = 0;
    int            b_m       = 2 * SLOT - 1;
    int            p_m       = 0;
    int            fs_cyc    = 0;
    int            fs_count  = 0;
    bit            fall_m    = 1'b0;
    bit            hv_m      = 1'b0;
    bit            ready_pre = 1'b0;
    bit            ur_set    = 1'b0;
    bit            bclk_m    = 1'b0;
    bit            lr_m      = 1'b0;
    bit            sd_m      = 1'b0;
    bit            ur_m      = 1'b0;
    logic [DW-1:0] hold_m    = '0;
    logic [DW-1:0] cur_m     = '0;

    // Slot words collected from the DUT, first bit sent in the MSB.
    logic [31:0]   slot_w    = '0;
    logic [31:0]   left_w    = '0;
    logic [31:0]   right_w   = '0;
    int            frames_done   = 0;
    int            frame_end_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        fall_m = 1'b0;
        ur_set = 1'b0;
        if (!(reset_n && enable)) begin
            n_edges = 0;
            hv_m    = 1'b0;
            cur_m   = '0;
            bclk_m  = 1'b0;
            lr_m    = 1'b0;
            sd_m    = 1'b0;
            ur_m    = 1'b0;
            b_m     = 2 * SLOT - 1;
        end else begin
            ready_pre = !hv_m;
            n_edges++;
            bclk_m = ((n_edges / DIV) % 2) == 1;
            if ((n_edges % (2 * DIV)) == 0) begin
                fall_m = 1'b1;
                b_m    = (n_edges / (2 * DIV) - 1) % (2 * SLOT);
                if (b_m == 0) begin
                    fs_cyc = cyc;
                    fs_count++;
                    if (hv_m) begin
                        cur_m = hold_m;
                        hv_m  = 1'b0;
                    end else begin
                        cur_m  = '0;
                        ur_set = 1'b1;
                    end
                end
                lr_m = (b_m >= SLOT);
                p_m  = b_m % SLOT;
                sd_m = (p_m >= 1 && p_m <= DW) ? (((cur_m >> (DW - p_m)) & 24'd1) != 0) : 1'b0;
            end
            if (ur_set) ur_m = 1'b1;
            else if (underrun_clear) ur_m = 1'b0;
            if (din_valid && ready_pre) begin
                hold_m = din;
                hv_m   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("bclk", i2s_bclk, bclk_m);
        check("lrclk", i2s_lrclk, lr_m);
        check("sdata", i2s_sdata, sd_m);
        check("underrun", underrun, ur_m);
        check("din_ready", din_ready, reset_n && enable && !hv_m);
        if (fall_m) begin
            slot_w = {slot_w[30:0], i2s_sdata};
            if (b_m == SLOT - 1) left_w = slot_w;
            if (b_m == 2 * SLOT - 1) begin
                right_w       = slot_w;
                frames_done   = frames_done + 1;
                frame_end_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] s);
        int k;
        din       = s;
        din_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!din_ready && k < 2000);
        check("send_ready", din_ready, 1);
        step();
        din_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frames_done < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait", frames_done, target);
    endtask

    task automatic wait_frame_start();
        int fs0;
        int k;
        fs0 = fs_count;
        k = 0;
        while (fs_count == fs0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("fs_wait", fs_count, fs0 + 1);
    endtask

    task automatic wait_bit40();
        int k;
        k = 0;
        while (!(fall_m && b_m == 40) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("bit40_wait", b_m, 40);
    endtask

    task automatic check_slots(input string name, input logic [31:0] exp);
        check({name, "_left"}, left_w, exp);
        check({name, "_right"}, right_w, exp);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_bclk"}, i2s_bclk, 0);
        check({name, "_lrclk"}, i2s_lrclk, 0);
        check({name, "_sdata"}, i2s_sdata, 0);
        check({name, "_underrun"}, underrun, 0);
        check({name, "_din_ready"}, din_ready, 0);
    endtask

    initial begin
        int t1;
        int rel_cyc;
        int fd;
        int ready_cyc;
        int k;

        reset_n        = 1'b0;
        enable         = 1'b1;
        din            = '0;
        din_valid      = 1'b0;
        underrun_clear = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");

        // Single sample and negative full scale on consecutive frames.
        step();
        reset_n = 1'b1;
        send(24'hABCDEF);
        send(24'h800000);
        wait_frames(1);
        check_slots("abcdef", 32'h55E6F780);
        t1 = frame_end_cyc;
        wait_frames(2);
        check_slots("neg_fs", 32'h40000000);
        check("frame_period", frame_end_cyc - t1, 256);
        check("neg_fs_underrun", underrun, 0);

        // Backpressure: din_valid held across two samples.
        step();
        din       = 24'h000001;
        din_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!din_ready && k < 2000);
        step();
        din = 24'h000002;
        k = 0;
        do begin @(negedge clk); k++; end while (!din_ready && k < 2000);
        ready_cyc = cyc;
        step();
        din_valid = 1'b0;
        check("accept_after_load", ready_cyc + 1 - fs_cyc, 1);
        wait_frames(3);
        check_slots("one", 32'h00000080);
        wait_frames(4);
        check_slots("two", 32'h00000100);

        // Underrun, clear, and set/clear collision.
        wait_frames(5);
        check_slots("underrun_frame", 32'h0);
        check("underrun_set", underrun, 1);
        step();
        underrun_clear = 1'b1;
        step();
        underrun_clear = 1'b0;
        @(negedge clk);
        check("underrun_cleared", underrun, 0);
        step();
        underrun_clear = 1'b1;
        wait_frame_start();
        check("set_beats_clear", underrun, 1);
        step();
        underrun_clear = 1'b0;

        // Reset mid-frame with a buffered sample.
        send(24'h123456);
        wait_bit40();
        step();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rel_cyc = cyc;
        wait_frame_start();
        check("reset_fs_delay", fs_cyc - rel_cyc, 4);
        fd = frames_done;
        wait_frames(fd + 1);
        check_slots("after_reset", 32'h0);
        check("after_reset_underrun", underrun, 1);

        // enable low for 10 cycles mid-stream behaves like reset.
        wait_frame_start();
        step();
        send(24'h654321);
        wait_bit40();
        step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("disabled_din_ready", din_ready, 0);
            if (i == 1) check_idle_outputs("disabled");
            @(posedge clk);
        end
        #1;
        enable  = 1'b1;
        rel_cyc = cyc;
        wait_frame_start();
        check("enable_fs_delay", fs_cyc - rel_cyc, 4);
        fd = frames_done;
        wait_frames(fd + 1);
        check_slots("after_enable", 32'h0);
        check("after_enable_underrun", underrun, 1);

        // Positive full scale after recovery.
        step();
        fd = frames_done;
        send(24'h7FFFFF);
        wait_frames(fd + 1);
        check_slots("pos_fs", 32'h3FFFFF80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_dac_transmitter.md
I2S_DAC_TRANSMITTER -- requirements
Module: i2s_dac_transmitter

Interface
REQ-001 SHALL have parameter G_DWIDTH, default 24: sample width in bits, 1..32.
REQ-002 SHALL have parameter G_BCLK_DIV, default 4: clk cycles per BCLK half-period, 1..255.
REQ-003 SHALL have parameter G_SLOT_BITS, default 32: BCLK periods per channel slot, at least G_DWIDTH+1.
REQ-004 SHALL have port clk, input, 1: the only clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port enable, input, 1: 0 has the same effect as reset, matching codebase block behaviour.
REQ-007 SHALL have ports din, din_valid and din_ready: input G_DWIDTH, input 1 and output 1; signed mono sample stream from the DSP chain.
REQ-008 SHALL have ports i2s_bclk, i2s_lrclk and i2s_sdata, each output 1: DAC serial bit clock, word select (0 = left) and data.
REQ-009 SHALL have port underrun_clear, input 1, and port underrun, output 1 (sticky flag).

Function
REQ-010 SHALL hold one-entry buffer hold_reg/hold_valid; din_ready = enable AND reset_n AND NOT hold_valid.
REQ-011 SHALL capture din into hold_reg and set hold_valid when din_valid=1 and din_ready=1; din SHALL NOT be sampled otherwise.
REQ-012 SHALL run div_cnt 0..G_BCLK_DIV-1 and toggle i2s_bclk on each div_cnt wrap; BCLK period = 2*G_BCLK_DIV clk.
REQ-013 "Fall event" = the cycle i2s_bclk goes 1->0; bit_cnt (0..2*G_SLOT_BITS-1, wraps) SHALL increment on each fall event, and all serial outputs SHALL update only then.
REQ-014 At a fall event with new bit_cnt b, slot position p = b mod G_SLOT_BITS: i2s_lrclk = (b >= G_SLOT_BITS); i2s_sdata = shift_reg[G_DWIDTH-p] for 1 <= p <= G_DWIDTH, else 0.
REQ-015 On the fall event where b becomes 0 (frame start): if hold_valid, shift_reg <= hold_reg and hold_valid SHALL clear the same cycle; else shift_reg <= 0 and underrun SHALL be set.
REQ-016 The same sample SHALL be sent in left and right slots (mono duplicated), MSB first, two's-complement unchanged.
REQ-017 Capture and frame-start load in the same cycle: load takes the old hold_reg; new capture is blocked because din_ready was 0, so no sample is lost or duplicated.
REQ-018 underrun_clear=1 SHALL clear underrun; if set and clear coincide, set wins.
REQ-019 Latency: a sample accepted before a frame start SHALL have its MSB on i2s_sdata at fall event b=1 of that frame.
REQ-020 Throughput: exactly one sample SHALL be consumed per frame of 2*G_SLOT_BITS BCLK periods.

Reset
REQ-021 While reset_n=0 or enable=0: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0, hold_valid=0, shift_reg=0, div_cnt=0, bit_cnt=2*G_SLOT_BITS-1 (the next fall event is frame start), din_ready=0.
REQ-022 Reset mid-frame SHALL abort the frame immediately and discard any buffered sample; after release, the first fall event SHALL occur G_BCLK_DIV*2 clk later and SHALL be a frame start.

Structure
REQ-023 C_ADC_DWIDTH (24) and C_I2S_SLOT_BITS (32) SHALL live in the shared tulip package and feed the parameter defaults.
REQ-024 BCLK divider and fall-event strobe SHALL be one sub-module, i2s_bclk_gen (div_cnt, i2s_bclk, fall strobe); the remaining logic stays in i2s_dac_transmitter.

Verification (G_BCLK_DIV=2, G_SLOT_BITS=32, G_DWIDTH=24)
REQ-025 Single sample: din=0xABCDEF before frame start -> both slots carry 1010_1011_1100_1101_1110_1111 at p=1..24 and zeros at p=0,25..31; i2s_lrclk period 256 clk.
REQ-026 Negative full-scale: din=0x800000 -> serial 1 then 23 zeros in each slot; underrun stays 0.
REQ-027 Backpressure: din_valid held with 0x000001 then 0x000002 -> second sample accepted only in the cycle after the frame-start load; consecutive frames carry 1 then 2.
REQ-028 Underrun: no input for a frame -> both slots all zero, underrun=1 until an underrun_clear pulse; set and clear in the same cycle -> underrun stays 1.
REQ-029 Reset mid-frame: reset_n=0 at bit_cnt=40 with a sample buffered -> all outputs 0 next cycle and buffered sample lost; after release, the first frame start occurs after 4 clk.
REQ-030 enable toggle: enable=0 for 10 cycles mid-stream -> identical to REQ-029; din_ready=0 throughout.
